uart_rx_fifo: RTL and testbench

Receive-byte buffer sitting directly downstream of the UART receive shifter. It accepts one byte per push from the shifter's stop-bit check, stores up to DEPTH bytes in a circular buffer, and delivers them in order to the UART controller / CPU bus side. It provides full and empty status, an occupancy count, a threshold interrupt, and sticky overflow and underflow error flags.

---
 rtl/uart_rx_fifo.sv | 101 ++++++++++
 tb/tb_uart_rx_fifo.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-byte FIFO between the UART receive shifter and the controller/CPU side.
// Define UART_RX_FIFO_FWFT_EN for first-word-fall-through reads; default is registered-read mode.
module uart_rx_fifo #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    input  logic [DEPTH_LOG2:0]   thresh,
    output logic                  irq,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    // Handshake: a push is taken on any edge where wr_en is high and there is room
    // (or a pop frees a slot in the same cycle); a pop is taken where rd_en is high
    // and the FIFO is not empty. Rejected requests never stall, they only set a sticky flag.

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0] count_d;
    logic                irq_q, overflow_q, underflow_q;
    logic                push_ok, pop_ok;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]) &&
                   (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);
    assign count = wr_ptr_q - rd_ptr_q;

    always_comb begin
        pop_ok   = rd_en && !empty;
        push_ok  = wr_en && (!full || pop_ok);
        wr_ptr_d = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        count_d  = wr_ptr_d - rd_ptr_d;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            irq_q       <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            irq_q       <= (thresh != '0) && (count_d >= thresh);
            // A fresh error in the clearing cycle keeps its flag set.
            overflow_q  <= (wr_en && !push_ok) || (overflow_q && !err_clr);
            underflow_q <= (rd_en && empty)    || (underflow_q && !err_clr);
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    assign irq       = irq_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

`ifdef UART_RX_FIFO_FWFT_EN
    assign rd_data  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign rd_valid = !empty;
`else
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= pop_ok;
            if (pop_ok) begin
                rd_data_q <= mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: scoreboard of pushed bytes, scenario tasks with inline checks.
module tb_uart_rx_fifo;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic [4:0] thresh = 5'd0;
    logic       irq;
    logic       overflow;
    logic       underflow;
    logic       err_clr = 1'b0;

    int         vectors = 0;
    int         miscompares = 0;
    int         mdl_cnt = 0;
    logic [7:0] exp_q[$];
    logic       exp_pop;
    logic       got_valid;
    logic [7:0] got_data;
    logic [7:0] exp_b;

    uart_rx_fifo #(.DATA_W(8), .DEPTH_LOG2(4)) dut (
        .CLK(CLK), .RST(RST),
        .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .empty(empty), .full(full), .count(count),
        .thresh(thresh), .irq(irq),
        .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    always #5 CLK = ~CLK;

    // One clock of stimulus; the model decides acceptance, outputs are sampled 1ns after the edge.
    task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic c);
        logic pop_ok, push_ok;
        wr_en = w; wr_data = d; rd_en = r; err_clr = c;
        pop_ok  = r && (mdl_cnt != 0);
        push_ok = w && ((mdl_cnt != 16) || pop_ok);
        exp_pop = pop_ok;
`ifdef UART_RX_FIFO_FWFT_EN
        got_valid = rd_valid;
        got_data  = rd_data;
`endif
        @(posedge CLK);
        #1;
        if (push_ok) exp_q.push_back(d);
        mdl_cnt = mdl_cnt + int'(push_ok) - int'(pop_ok);
`ifndef UART_RX_FIFO_FWFT_EN
        got_valid = rd_valid;
        got_data  = rd_data;
`endif
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    endtask

    task automatic test_reset;
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got=%b exp=1", empty); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full got=%b exp=0", full); end
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", count); end
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        vectors++; if ({irq, overflow, underflow} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got=%b exp=000", {irq, overflow, underflow}); end
`ifndef UART_RX_FIFO_FWFT_EN
        vectors++; if (rd_data !== 8'h00) begin miscompares++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
`endif
    endtask

    task automatic test_basic;
        logic [7:0] bytes [3];
        bytes[0] = 8'h41; bytes[1] = 8'h42; bytes[2] = 8'h43;
        for (int i = 0; i < 3; i++) drive(1'b1, bytes[i], 1'b0, 1'b0);
        vectors++; if (count !== 5'd3) begin miscompares++; $display("FAIL basic_count3 got=%0d exp=3", count); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            vectors++;
            if (got_valid !== 1'b1 || exp_q.size() == 0) begin
                miscompares++; $display("FAIL basic_valid got=%b exp=1", got_valid);
            end else begin
                exp_b = exp_q.pop_front();
                if (got_data !== exp_b) begin miscompares++; $display("FAIL basic_data got=%h exp=%h", got_data, exp_b); end
            end
            vectors++; if (count !== 5'(2 - i)) begin miscompares++; $display("FAIL basic_count got=%0d exp=%0d", count, 2 - i); end
        end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL basic_empty got=%b exp=1", empty); end
        vectors++; if ({overflow, underflow} !== 2'b00) begin miscompares++; $display("FAIL basic_errs got=%b exp=00", {overflow, underflow}); end
    endtask

    task automatic test_full_overflow;
        for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
        vectors++; if (full !== 1'b1 || count !== 5'd16) begin miscompares++; $display("FAIL full_status got=%b/%0d exp=1/16", full, count); end
        drive(1'b1, 8'hAA, 1'b0, 1'b0);
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL overflow_set got=%b exp=1", overflow); end
        vectors++; if (count !== 5'd16) begin miscompares++; $display("FAIL overflow_count got=%0d exp=16", count); end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            vectors++;
            if (got_valid !== exp_pop || exp_q.size() == 0) begin
                miscompares++; $display("FAIL drain_valid got=%b exp=%b", got_valid, exp_pop);
            end else begin
                exp_b = exp_q.pop_front();
                if (got_data !== exp_b) begin miscompares++; $display("FAIL drain_data got=%h exp=%h", got_data, exp_b); end
            end
        end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL drain_empty got=%b exp=1", empty); end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL overflow_clr got=%b exp=0", overflow); end
    endtask

    task automatic test_full_push_pop;
        for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
        drive(1'b1, 8'h55, 1'b1, 1'b0);
        vectors++;
        if (got_valid !== 1'b1 || exp_q.size() == 0) begin
            miscompares++; $display("FAIL fullpp_valid got=%b exp=1", got_valid);
        end else begin
            exp_b = exp_q.pop_front();
            if (got_data !== exp_b) begin miscompares++; $display("FAIL fullpp_data got=%h exp=%h", got_data, exp_b); end
        end
        vectors++; if (count !== 5'd16 || full !== 1'b1) begin miscompares++; $display("FAIL fullpp_count got=%0d/%b exp=16/1", count, full); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL fullpp_overflow got=%b exp=0", overflow); end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            vectors++;
            if (got_valid !== 1'b1 || exp_q.size() == 0) begin
                miscompares++; $display("FAIL fullpp_drain_valid got=%b exp=1", got_valid);
            end else begin
                exp_b = exp_q.pop_front();
                if (got_data !== exp_b) begin miscompares++; $display("FAIL fullpp_drain_data got=%h exp=%h", got_data, exp_b); end
            end
        end
    endtask

    task automatic test_underflow;
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL underflow_set got=%b exp=1", underflow); end
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL underflow_rd_valid got=%b exp=0", rd_valid); end
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL underflow_set_wins got=%b exp=1", underflow); end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL underflow_clr got=%b exp=0", underflow); end
        drive(1'b1, 8'h77, 1'b1, 1'b0);
        vectors++; if (underflow !== 1'b1 || count !== 5'd1) begin miscompares++; $display("FAIL underflow_with_push got=%b/%0d exp=1/1", underflow, count); end
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++; $display("FAIL underflow_pop got=empty_model exp=1 entry");
        end else begin
            exp_b = exp_q.pop_front();
            if (got_data !== exp_b || underflow !== 1'b0) begin miscompares++; $display("FAIL underflow_pop got=%h/%b exp=%h/0", got_data, underflow, exp_b); end
        end
    endtask

    task automatic test_irq;
        thresh = 5'd4;
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_below got=%b exp=0", irq); end
        drive(1'b1, 8'hC3, 1'b0, 1'b0);
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_at got=%b exp=1", irq); end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        if (exp_q.size() != 0) exp_b = exp_q.pop_front();
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_after_pop got=%b exp=0", irq); end
        thresh = 5'd0;
        drive(1'b1, 8'hC4, 1'b0, 1'b0);
        drive(1'b1, 8'hC5, 1'b0, 1'b0);
        vectors++; if (irq !== 1'b0 || count !== 5'd5) begin miscompares++; $display("FAIL irq_thresh0 got=%b/%0d exp=0/5", irq, count); end
        thresh = 5'd16;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_thresh16 got=%b exp=0", irq); end
        thresh = 5'd0;
        while (mdl_cnt != 0) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++; $display("FAIL irq_drain got=empty_model exp=entry");
            end else begin
                exp_b = exp_q.pop_front();
                if (got_data !== exp_b) begin miscompares++; $display("FAIL irq_drain_data got=%h exp=%h", got_data, exp_b); end
            end
        end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0);
        drive(1'b1, 8'hD4, 1'b1, 1'b0);
        #2;
        RST = 1'b1;
        #1;
        vectors++; if (empty !== 1'b1 || count !== 5'd0) begin miscompares++; $display("FAIL async_rst_status got=%b/%0d exp=1/0", empty, count); end
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL async_rst_rd_valid got=%b exp=0", rd_valid); end
        exp_q.delete();
        mdl_cnt = 0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic test_wrap;
        drive(1'b1, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 8'(i + 2), 1'b1, 1'b0);
            vectors++;
            if (got_valid !== 1'b1 || exp_q.size() == 0) begin
                miscompares++; $display("FAIL wrap_valid i=%0d got=%b exp=1", i, got_valid);
            end else begin
                exp_b = exp_q.pop_front();
                if (got_data !== exp_b || count !== 5'd2) begin miscompares++; $display("FAIL wrap_data i=%0d got=%h/%0d exp=%h/2", i, got_data, count, exp_b); end
            end
        end
        for (int i = 0; i < 120; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
            vectors++;
            if (got_valid !== exp_pop) begin
                miscompares++; $display("FAIL rand_valid i=%0d got=%b exp=%b", i, got_valid, exp_pop);
            end else if (got_valid) begin
                if (exp_q.size() == 0) begin
                    miscompares++; $display("FAIL rand_data i=%0d got=%h exp=none", i, got_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (got_data !== exp_b) begin miscompares++; $display("FAIL rand_data i=%0d got=%h exp=%h", i, got_data, exp_b); end
                end
            end
            vectors++;
            if (count !== 5'(mdl_cnt) || empty !== (mdl_cnt == 0) || full !== (mdl_cnt == 16)) begin
                miscompares++; $display("FAIL rand_status i=%0d got=%0d/%b/%b exp=%0d", i, count, empty, full, mdl_cnt);
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        test_reset();
        RST = 1'b0;
        test_basic();
        test_full_overflow();
        test_full_push_pop();
        test_underflow();
        test_irq();
        test_async_reset();
        test_reset();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
